serial_sub_8bit: RTL and testbench

SERIAL_SUB_8BIT -- requirements
Module: serial_sub_8bit

---
 rtl/serial_sub_pkg.sv | 24 ++
 rtl/full_adder.sv | 20 ++
 rtl/serial_sub_8bit.sv | 155 +++++++++++++++
 tb/tb_serial_sub_8bit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_sub_pkg
// Description : Shared definitions for the bit-serial subtractor: FSM state
//               encoding, default operand width and bit-counter sizing.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_sub_pkg;

    localparam int c_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter must index 0..w-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage : serial_sub_pkg
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module      : full_adder
// Description : Single-bit full adder cell.
//               Ports: a, b, cin (inputs)  -> s (sum), cout (carry out)
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder
`default_nettype wire

// File: rtl/serial_sub_8bit.sv
`default_nettype none
// ============================================================================
// Module      : serial_sub_8bit
// Description : Bit-serial subtractor computing d = a - b - bin as
//               a + ~b + ~bin, LSB first, one bit per clock through a single
//               full-adder cell and a one-bit carry register.
//   Ports:
//     clk   - clock, rising edge
//     rst   - synchronous active-high reset
//     start - request, honoured only in IDLE or DONE
//     a, b  - minuend / subtrahend (WIDTH bits), captured on acceptance
//     bin   - borrow in, captured on acceptance
//     busy  - high while the serial operation runs
//     done  - one-cycle pulse, results valid
//     d     - difference modulo 2^WIDTH
//     bout  - borrow out (~c7)
//     c6    - carry into the MSB of the internal sum
//     c7    - carry out of the MSB of the internal sum
//     ovf   - signed overflow (c6 ^ c7)
// Revision    : 1.0 - initial release
// ============================================================================
module serial_sub_8bit
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             c6,
    output logic             c7,
    output logic             ovf
);

    localparam int                CNT_W  = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  c_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   nb_q, nb_d;      // inverted subtrahend
    logic [WIDTH-1:0]   acc_q, acc_d;    // sum bits shifted in from the top
    logic [WIDTH-1:0]   d_q, d_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               bout_q, bout_d;
    logic               c6_q, c6_d;
    logic               c7_q, c7_d;
    logic               ovf_q, ovf_d;

    logic               w_fa_a;
    logic               w_fa_b;
    logic               w_sum;
    logic               w_cout;

    assign w_fa_a = a_q[cnt_q];
    assign w_fa_b = nb_q[cnt_q];

    full_adder u_fa (
        .a    (w_fa_a),
        .b    (w_fa_b),
        .cin  (carry_q),
        .s    (w_sum),
        .cout (w_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        nb_d    = nb_q;
        acc_d   = acc_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        bout_d  = bout_q;
        c6_d    = c6_q;
        c7_d    = c7_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    nb_d    = ~b;
                    carry_d = ~bin;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d   = {w_sum, acc_q[WIDTH-1:1]};
                carry_d = w_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == c_LAST) begin
                    // Final bit: publish the result and the MSB carries.
                    d_d     = {w_sum, acc_q[WIDTH-1:1]};
                    c6_d    = carry_q;
                    c7_d    = w_cout;
                    ovf_d   = carry_q ^ w_cout;
                    bout_d  = ~w_cout;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            nb_q    <= '0;
            acc_q   <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            bout_q  <= 1'b0;
            c6_q    <= 1'b0;
            c7_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            nb_q    <= nb_d;
            acc_q   <= acc_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            bout_q  <= bout_d;
            c6_q    <= c6_d;
            c7_q    <= c7_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign d    = d_q;
    assign bout = bout_q;
    assign c6   = c6_q;
    assign c7   = c7_q;
    assign ovf  = ovf_q;

endmodule : serial_sub_8bit
`default_nettype wire

// File: tb/tb_serial_sub_8bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_sub_8bit
// Description : Directed self-checking bench for serial_sub_8bit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_sub_8bit;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       busy;
    logic       done;
    logic [7:0] d;
    logic       bout;
    logic       c6;
    logic       c7;
    logic       ovf;

    int tests_run = 0;
    int tests_failed = 0;

    serial_sub_8bit #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout),
        .c6    (c6),
        .c7    (c7),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input string what,
                       input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        assert (got === exp) else begin
            tests_failed++;
            $error("FAIL %s.%s: observed 0x%0h expected 0x%0h", tag, what, got, exp);
        end
    endtask

    // Launch one operation, scramble the inputs after acceptance, and check
    // latency, results, the single-cycle done pulse and result hold.
    task automatic run_op(input string tag,
                          input logic [7:0] ta, input logic [7:0] tb_,
                          input logic tbin, input logic [7:0] ed,
                          input logic eb, input logic e6,
                          input logic e7, input logic eo);
        logic [7:0] prev;
        int lat;
        @(negedge clk);
        a = ta; b = tb_; bin = tbin; start = 1'b1;
        prev = d;
        @(posedge clk); #1;
        start = 1'b0;
        a = ~ta; b = ~tb_; bin = ~tbin;
        chk(tag, "busy_on_accept", busy, 1);
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (n == 4) chk(tag, "d_hidden_in_run", d, prev);
            if (done === 1'b1) begin
                lat = n;
                break;
            end
        end
        chk(tag, "latency", lat, 8);
        chk(tag, "d", d, ed);
        chk(tag, "bout", bout, eb);
        chk(tag, "c6", c6, e6);
        chk(tag, "c7", c7, e7);
        chk(tag, "ovf", ovf, eo);
        chk(tag, "busy_in_done", busy, 0);
        @(posedge clk); #1;
        chk(tag, "done_pulse_one_cycle", done, 0);
        chk(tag, "d_held", d, ed);
    endtask

    initial begin
        int lat;
        int gap;
        int ndone;

        rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; bin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", "busy", busy, 0);
        chk("reset", "done", done, 0);
        chk("reset", "d", d, 0);
        chk("reset", "flags", {bout, c6, c7, ovf}, 0);

        // start coincident with reset is ignored
        @(negedge clk); start = 1'b1; a = 8'h12; b = 8'h34;
        @(posedge clk); #1;
        chk("start_in_rst", "busy", busy, 0);
        @(negedge clk); start = 1'b0; rst = 1'b0;

        run_op("basic",   8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b1, 1'b1, 1'b0);
        run_op("borrow",  8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op("ovf",     8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b1);
        run_op("bin_ovf", 8'h55, 8'hAA, 1'b1, 8'hAA, 1'b1, 1'b1, 1'b0, 1'b1);
        run_op("ff_ff_b", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);

        // start pulsed mid-RUN with other operands must be ignored
        @(negedge clk); a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); a = 8'h80; b = 8'h01; bin = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        lat = 0;
        for (int n = 5; n <= 24; n++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                lat = n;
                break;
            end
        end
        chk("midrun_start", "latency", lat, 8);
        chk("midrun_start", "d", d, 8'h02);
        chk("midrun_start", "flags", {bout, c6, c7, ovf}, 4'b0110);
        @(posedge clk); #1;
        chk("midrun_start", "no_restart", busy, 0);

        // reset while processing bit 4 abandons the operation
        @(negedge clk); a = 8'h00; b = 8'h01; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_midrun", "busy", busy, 0);
        chk("rst_midrun", "done", done, 0);
        chk("rst_midrun", "d", d, 0);
        chk("rst_midrun", "flags", {bout, c6, c7, ovf}, 0);
        @(negedge clk); rst = 1'b0;
        ndone = 0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
        end
        chk("rst_midrun", "no_done", ndone, 0);
        run_op("after_rst", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b1, 1'b1, 1'b0);

        // start held high: back-to-back operations every WIDTH+1 cycles
        @(negedge clk); a = 8'h80; b = 8'h01; bin = 1'b0; start = 1'b1;
        lat = 0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                lat = n;
                break;
            end
        end
        chk("b2b", "first_latency", lat, 9);
        gap = 0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                gap = n;
                break;
            end
        end
        chk("b2b", "period", gap, 9);
        chk("b2b", "d", d, 8'h7F);
        chk("b2b", "ovf", ovf, 1);
        @(negedge clk); start = 1'b0;
        repeat (12) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_serial_sub_8bit
`default_nettype wire
